// File: rtl/lemming_world.sv
// ============================================================================
// Module   : lemming_world
// Brief    : 1-D track environment and protocol checker for a lemming walker.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lemming_world #(
  parameter int unsigned           TRACK_LEN   = 16,
  parameter int unsigned           POS_W       = 4,
  parameter int unsigned           FALL_CYCLES = 3,
  parameter int unsigned           START_POS   = 0,
  parameter logic [TRACK_LEN-1:0]  HOLE_INIT   = '0
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic                 walk_left,
  input  logic                 walk_right,
  input  logic                 aaah,
  input  logic                 step_en,
  input  logic                 cfg_load,
  input  logic [TRACK_LEN-1:0] hole_cfg,
  output logic                 bump_left,
  output logic                 bump_right,
  output logic                 ground,
  output logic [POS_W-1:0]     pos,
  output logic                 falling,
  output logic [7:0]           fall_count,
  output logic                 proto_err
);

  localparam int unsigned    CTR_W      = (FALL_CYCLES > 1) ? $clog2(FALL_CYCLES) : 1;
  localparam logic [CTR_W-1:0] C_LAST_CTR = CTR_W'(FALL_CYCLES - 1);
  localparam logic [POS_W-1:0] C_LAST_POS = POS_W'(TRACK_LEN - 1);
  localparam logic [POS_W-1:0] C_START    = POS_W'(START_POS);

  typedef enum logic [0:0] {
    S_WALK = 1'b0,
    S_FALL = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [TRACK_LEN-1:0] holes_q, holes_d;
  logic [CTR_W-1:0]     fall_ctr_q, fall_ctr_d;
  logic [7:0]           fall_count_q, fall_count_d;
  logic                 proto_err_q, proto_err_d;
  logic                 aaah_alone_q, aaah_alone_d;

  logic w_walking;
  logic w_ground;
  logic w_onehot;

  assign w_walking  = (state_q == S_WALK);
  assign w_ground   = w_walking && !holes_q[pos_q];
  // Exactly one of three set: odd parity, but not all three.
  assign w_onehot   = (walk_left ^ walk_right ^ aaah) && !(walk_left && walk_right && aaah);

  assign ground     = w_ground;
  assign bump_left  = w_walking && walk_left  && (pos_q == '0);
  assign bump_right = w_walking && walk_right && (pos_q == C_LAST_POS);
  assign falling    = (state_q == S_FALL);
  assign pos        = pos_q;
  assign fall_count = fall_count_q;
  assign proto_err  = proto_err_q;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q      <= S_WALK;
      pos_q        <= C_START;
      holes_q      <= HOLE_INIT;
      fall_ctr_q   <= '0;
      fall_count_q <= '0;
      proto_err_q  <= 1'b0;
      aaah_alone_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      holes_q      <= holes_d;
      fall_ctr_q   <= fall_ctr_d;
      fall_count_q <= fall_count_d;
      proto_err_q  <= proto_err_d;
      aaah_alone_q <= aaah_alone_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    holes_d      = holes_q;
    fall_ctr_d   = fall_ctr_q;
    fall_count_d = fall_count_q;

    case (state_q)
      S_WALK: begin
        if (!w_ground) begin
          state_d    = S_FALL;
          fall_ctr_d = '0;
        end else if (step_en) begin
          if (walk_left && (pos_q != '0)) begin
            pos_d = pos_q - POS_W'(1);
          end else if (walk_right && (pos_q != C_LAST_POS)) begin
            pos_d = pos_q + POS_W'(1);
          end
        end
      end
      S_FALL: begin
        if (fall_ctr_q == C_LAST_CTR) begin
          state_d        = S_WALK;
          holes_d[pos_q] = 1'b0;
          if (fall_count_q != 8'hFF) begin
            fall_count_d = fall_count_q + 8'd1;
          end
        end else begin
          fall_ctr_d = fall_ctr_q + CTR_W'(1);
        end
      end
      default: state_d = S_WALK;
    endcase

    // A fresh map overrides the landing clear on the same edge.
    if (cfg_load) begin
      holes_d = hole_cfg;
    end
  end

  // The walker may lag one cycle leaving its fall, so only a second
  // consecutive aaah outside FALL is a violation.
  always_comb begin
    aaah_alone_d = aaah && !falling;
    proto_err_d  = proto_err_q || !w_onehot || (aaah_alone_d && aaah_alone_q);
  end

endmodule

`default_nettype wire

// File: tb/tb_lemming_world.sv
// ============================================================================
// Module   : tb_lemming_world
// Brief    : Closed-loop bench: behavioural walker + world model vs lemming_world.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lemming_world;

  localparam int TL = 16;
  localparam int FC = 3;

  logic          clk = 1'b0;
  logic          areset_n;
  logic          walk_left, walk_right, aaah, step_en, cfg_load;
  logic [TL-1:0] hole_cfg;
  logic          bump_left, bump_right, ground, falling, proto_err;
  logic [3:0]    pos;
  logic [7:0]    fall_count;

  lemming_world #(
    .TRACK_LEN(TL), .POS_W(4), .FALL_CYCLES(FC), .START_POS(0), .HOLE_INIT(16'h0000)
  ) dut (
    .clk(clk), .areset_n(areset_n),
    .walk_left(walk_left), .walk_right(walk_right), .aaah(aaah),
    .step_en(step_en), .cfg_load(cfg_load), .hole_cfg(hole_cfg),
    .bump_left(bump_left), .bump_right(bump_right), .ground(ground),
    .pos(pos), .falling(falling), .fall_count(fall_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // World model: plain integers, falls tracked as cycles remaining.
  int      m_pos, m_rem, m_cnt;
  bit      m_fall, m_err, m_prev_alone;
  bit [TL-1:0] m_holes;
  // Walker model: direction (1 = right) and falling flag.
  bit      w_dir, w_fall;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit e_ground();
    return !m_fall && !m_holes[m_pos];
  endfunction
  function automatic bit e_bl();
    return !m_fall && walk_left && (m_pos == 0);
  endfunction
  function automatic bit e_br();
    return !m_fall && walk_right && (m_pos == TL - 1);
  endfunction

  task automatic model_reset();
    m_pos = 0; m_rem = 0; m_cnt = 0; m_fall = 0; m_err = 0; m_prev_alone = 0;
    m_holes = '0;
  endtask

  task automatic model_step();
    bit alone;
    if (int'(walk_left) + int'(walk_right) + int'(aaah) != 1) m_err = 1;
    alone = aaah && !m_fall;
    if (alone && m_prev_alone) m_err = 1;
    m_prev_alone = alone;
    if (!m_fall) begin
      if (m_holes[m_pos]) begin
        m_fall = 1;
        m_rem  = FC;
      end else if (step_en) begin
        if (walk_left && m_pos > 0) m_pos--;
        else if (walk_right && m_pos < TL - 1) m_pos++;
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_fall = 0;
        m_holes[m_pos] = 1'b0;
        if (m_cnt < 255) m_cnt++;
      end
    end
    if (cfg_load) m_holes = hole_cfg;
  endtask

  task automatic walker_step(input bit g, input bit bl, input bit br);
    if (w_fall) begin
      if (g) w_fall = 0;
    end else if (!g) w_fall = 1;
    else if (bl) w_dir = 1;
    else if (br) w_dir = 0;
  endtask

  task automatic drive_walker();
    walk_left  = !w_fall && !w_dir;
    walk_right = !w_fall && w_dir;
    aaah       = w_fall;
  endtask

  // inj: 1 = both walk bits, 2 = lone aaah, 3 = all zero.
  task automatic tick(input bit se, input bit ld, input logic [TL-1:0] cfg, input int inj);
    bit g, bl, br;
    @(posedge clk);
    g = e_ground(); bl = e_bl(); br = e_br();
    model_step();
    walker_step(g, bl, br);
    #2;
    drive_walker();
    step_en = se; cfg_load = ld; hole_cfg = cfg;
    case (inj)
      1: begin walk_left = 1; walk_right = 1; aaah = 0; step_en = 0; end
      2: begin walk_left = 0; walk_right = 0; aaah = 1; step_en = 0; end
      3: begin walk_left = 0; walk_right = 0; aaah = 0; step_en = 0; end
      default: ;
    endcase
  endtask

  task automatic reset_assert(input bit dir);
    #1;
    areset_n = 1'b0;
    model_reset();
    w_dir = dir; w_fall = 0;
    drive_walker();
    step_en = 0; cfg_load = 0; hole_cfg = '0;
    #1;
  endtask

  task automatic reset_release();
    @(negedge clk);
    #2 areset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ground",     int'(ground),     int'(e_ground()));
      chk("bump_left",  int'(bump_left),  int'(e_bl()));
      chk("bump_right", int'(bump_right), int'(e_br()));
      chk("falling",    int'(falling),    int'(m_fall));
      chk("pos",        int'(pos),        m_pos);
      chk("fall_count", int'(fall_count), m_cnt);
      chk("proto_err",  int'(proto_err),  int'(m_err));
    end
  end

  initial begin
    int n;
    areset_n = 1'b0;
    model_reset();
    w_dir = 0; w_fall = 0;
    drive_walker();
    step_en = 0; cfg_load = 0; hole_cfg = '0;
    #12;
    chk_en = 1'b1;
    chk("rst_bump_left", int'(bump_left), 1);
    chk("rst_ground",    int'(ground),    1);
    chk("rst_pos",       int'(pos),       0);
    chk("rst_falling",   int'(falling),   0);
    areset_n = 1'b1;

    // Turn at the left wall, then five steps right.
    tick(1, 0, '0, 0);
    repeat (5) tick(1, 0, '0, 0);
    #1;
    chk("walk5_pos",   int'(pos),       5);
    chk("walk5_proto", int'(proto_err), 0);

    // Right wall bounce.
    n = 0;
    while (pos != 4'd15 && n < 20) begin tick(1, 0, '0, 0); n++; end
    #1;
    chk("reach15_timeout", int'(n < 20), 1);
    chk("bump_right_at15", int'(bump_right), 1);
    tick(1, 0, '0, 0); #1;
    chk("hold15", int'(pos), 15);
    tick(1, 0, '0, 0); #1;
    chk("back14", int'(pos), 14);

    // Hole at cell 3, fall, landing coinciding with a new map 0x0001.
    tick(1, 1, 16'h0008, 0);
    n = 0;
    while (pos != 4'd3 && n < 30) begin tick(1, 0, '0, 0); n++; end
    #1;
    chk("reach3_timeout", int'(n < 30), 1);
    chk("hole3_ground",   int'(ground),  0);
    chk("hole3_falling",  int'(falling), 0);
    for (int i = 0; i < FC; i++) begin
      tick(1, (i == FC - 1), 16'h0001, 0); #1;
      chk("fall3_falling", int'(falling), 1);
      chk("fall3_pos",     int'(pos),     3);
    end
    tick(1, 0, '0, 0); #1;
    chk("land3_falling", int'(falling),    0);
    chk("land3_ground",  int'(ground),     1);
    chk("land3_count",   int'(fall_count), 1);
    n = 0;
    while (!(falling && pos == 4'd0) && n < 20) begin tick(1, 0, '0, 0); n++; end
    chk("fall0_timeout", int'(n < 20), 1);
    n = 0;
    while (falling && n < 10) begin tick(1, 0, '0, 0); n++; end
    #1;
    chk("land0_count",  int'(fall_count), 2);
    repeat (40) tick(1, 0, '0, 0);
    #1;
    chk("no_refall_count", int'(fall_count), 2);

    // Non-one-hot walker vector sets a sticky error.
    #1 chk("pre_proto", int'(proto_err), 0);
    tick(0, 0, '0, 1);
    tick(1, 0, '0, 0); #1;
    chk("proto_set", int'(proto_err), 1);
    repeat (5) tick(1, 0, '0, 0);
    #1 chk("proto_held", int'(proto_err), 1);
    reset_assert(0);
    chk("proto_cleared", int'(proto_err), 0);
    reset_release();

    // Reset during the second FALL cycle aborts the fall.
    tick(0, 1, 16'h0001, 0);
    tick(0, 0, '0, 0); #1;
    chk("cfg_hole_ground", int'(ground), 0);
    tick(0, 0, '0, 0); #1;
    chk("fall1", int'(falling), 1);
    tick(0, 0, '0, 0);
    reset_assert(0);
    chk("abort_falling", int'(falling),    0);
    chk("abort_pos",     int'(pos),        0);
    chk("abort_count",   int'(fall_count), 0);
    chk("abort_ground",  int'(ground),     1);
    reset_release();

    // Continuous falls under an all-holes map: saturation at 255.
    repeat (1100) tick(0, 1, 16'hFFFF, 0);
    #1;
    chk("sat_count", int'(fall_count), 255);
    chk("sat_proto", int'(proto_err),  0);
    reset_assert(1);
    reset_release();

    // Randomised closed-loop run.
    for (int k = 0; k < 3000; k++) begin
      int r;
      bit se, ld;
      logic [TL-1:0] cfg;
      int inj;
      r   = $urandom_range(0, 999);
      if (r < 3) begin
        reset_assert(bit'($urandom_range(0, 1)));
        reset_release();
      end else begin
        se  = ($urandom_range(0, 3) != 0);
        ld  = ($urandom_range(0, 19) == 0);
        cfg = TL'($urandom & $urandom & $urandom);
        inj = (r < 12) ? int'($urandom_range(1, 3)) : 0;
        tick(se, ld, cfg, inj);
      end
    end

    @(posedge clk);
    #2 chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lemming_world.md
Name: lemming_world

Overview:
- Environment model that sits on the far side of the lemming walker FSM interface.
- Consumes the walker's Moore outputs (walk_left, walk_right, aaah) and produces its inputs (bump_left, bump_right, ground).
- Models a 1-D track with walls at both ends, configurable holes, a fixed-duration fall and hole filling on landing.
- Used as a closed-loop partner for walker FSMs in system sims, and as a protocol checker on the walker outputs.

Parameters:
- TRACK_LEN, 16, number of track cells; positions 0..TRACK_LEN-1; minimum 2.
- POS_W, 4, width of pos; must satisfy 2**POS_W >= TRACK_LEN.
- FALL_CYCLES, 3, cycles spent in FALL before landing; minimum 1.
- START_POS, 0, position loaded on reset.
- HOLE_INIT, 0, TRACK_LEN-bit hole map loaded on reset; bit i=1 means a hole at cell i.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- areset_n  input  1  asynchronous active-low reset.
- walk_left  input  1  from walker: walking left.
- walk_right  input  1  from walker: walking right.
- aaah  input  1  from walker: falling.
- step_en  input  1  movement strobe; position advances only on cycles where it is 1.
- cfg_load  input  1  loads hole_cfg into the hole map.
- hole_cfg  input  TRACK_LEN  new hole map.
- bump_left  output  1  to walker: left wall hit.
- bump_right  output  1  to walker: right wall hit.
- ground  output  1  to walker: floor present.
- pos  output  POS_W  current lemming cell.
- falling  output  1  world is in FALL.
- fall_count  output  8  number of completed landings; saturates at 255.
- proto_err  output  1  sticky protocol violation flag.

Behaviour:
- Reset (areset_n=0, asynchronous):
  - state=WALK, pos=START_POS, holes=HOLE_INIT, fall_ctr=0, fall_count=0, proto_err=0.
  - Outputs settle combinationally from the reset state. ground=!HOLE_INIT[START_POS]. bump_left and bump_right depend on the walker inputs. falling=0.
- Combinational outputs, all registered-state based, with no combinational path from step_en or cfg_load:
  - ground = (state==WALK) && !holes[pos].
  - bump_left = (state==WALK) && walk_left && (pos==0).
  - bump_right = (state==WALK) && walk_right && (pos==TRACK_LEN-1).
  - falling = (state==FALL).
- WALK state, ground=1, step_en=1:
  - walk_left && pos!=0 -> pos-1.
  - walk_right && pos!=TRACK_LEN-1 -> pos+1.
  - At a wall: no move. The bump is presented and the walker turns.
- WALK state, ground=1, step_en=0: pos holds.
- WALK state, ground=0 (standing on a hole): next state=FALL, fall_ctr=0, pos holds. step_en is ignored.
- FALL state: pos frozen, ground=0.
  - fall_ctr increments each cycle.
  - When fall_ctr==FALL_CYCLES-1: next state=WALK, holes[pos] cleared (hole filled), fall_count incremented with saturation at 255.
  - Result: ground drops for exactly FALL_CYCLES+1 cycles per hole (1 WALK cycle on the hole plus FALL_CYCLES cycles).
- Hole map updates:
  - cfg_load=1: holes<=hole_cfg on the next edge.
  - If a landing clear coincides, cfg_load wins: hole_cfg is taken verbatim.
  - Loading a hole under the current pos in WALK makes ground=0 next cycle, and the normal fall follows.
- proto_err is set (sticky until reset) on any edge where:
  - the walker input vector {walk_left, walk_right, aaah} is not one-hot; or
  - aaah=1 while falling=0 for 2 consecutive cycles. One cycle is allowed, because the walker leaves FALL one cycle after ground returns.
- Track wrap-around never occurs; pos is clamped by walls.
- Reset asserted mid-fall aborts the fall. fall_count is not incremented.

Test Plan:
- Reset with START_POS=0, HOLE_INIT=0, walker walking left -> bump_left=1, ground=1, pos=0. After the walker turns and 5 cycles of step_en=1: pos=5, proto_err=0.
- Walk right to pos=15 with no holes -> bump_right=1 in the cycle pos==15. pos stays 15 for that step, then decrements after the turn.
- HOLE_INIT bit 3 set, walking right from 0 with step_en=1 ->
  - pos reaches 3 and ground=0 that cycle;
  - falling=1 for exactly 3 cycles with pos=3;
  - then ground=1, fall_count=1, holes[3]=0;
  - walking resumes in the pre-fall direction with no second fall at cell 3.
- cfg_load with hole_cfg=0x0001 asserted on the same edge as the landing clear of cell 3 -> holes=0x0001 (cfg wins). Later arrival at pos 0 triggers a fall.
- Drive walk_left=walk_right=1 for one cycle -> proto_err=1 from the next edge, held until areset_n pulses low, then 0.
- areset_n low during the second FALL cycle -> immediately state=WALK, pos=START_POS, fall_count unchanged from reset value 0, falling=0.
